// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT peak detector slice.
// The PEAK_THRESH_EN macro adds threshold gating in fft_bin_counter and fft_peak_detect.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC    = 2'd1,
        ST_REPORT = 2'd2
    } fft_state_t;

    localparam int unsigned MAG_W           = 32;
    localparam int unsigned FFT_LEN_DEFAULT = 1024;

endpackage

// File: rtl/fft_bin_counter.sv
// Bin index tracking, end-of-frame (overrun) detection and per-beat peak eligibility.
// Optional macro PEAK_THRESH_EN: eligibility additionally requires data_modulus > thresh.
module fft_bin_counter
    import fft_pkg::*;
#(
    parameter int unsigned FFT_LEN   = FFT_LEN_DEFAULT,
    parameter int unsigned BIN_W     = 10,
    parameter int unsigned HALF_SPEC = 1,
    parameter int unsigned SKIP_DC   = 1
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             restart,
`ifdef PEAK_THRESH_EN
    input  logic [MAG_W-1:0] data_modulus,
    input  logic [MAG_W-1:0] thresh,
`endif
    output logic [BIN_W-1:0] cur_bin,
    output logic             last_bin,
    output logic             eligible
);

    localparam logic [BIN_W-1:0] LAST_IDX = BIN_W'(FFT_LEN - 1);
    localparam logic [BIN_W-1:0] HALF_IDX = BIN_W'(FFT_LEN / 2);

    logic [BIN_W-1:0] bin_q;
    logic             half_ok;
    logic             dc_ok;
    logic             thr_ok;

    // bin_q holds the index of the last accepted beat; the current beat is one past it
    always_comb begin
        cur_bin  = restart ? '0 : bin_q + BIN_W'(1);
        last_bin = (cur_bin == LAST_IDX);
    end

    always_comb begin
        half_ok = (HALF_SPEC == 0) || (cur_bin < HALF_IDX);
        dc_ok   = (SKIP_DC == 0) || (cur_bin != '0);
`ifdef PEAK_THRESH_EN
        thr_ok  = (data_modulus > thresh);
`else
        thr_ok  = 1'b1;
`endif
        eligible = half_ok && dc_ok && thr_ok;
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= '0;
        end else if (advance) begin
            bin_q <= cur_bin;
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Per-frame spectral peak search with framing error and dropped-frame reporting.
// Optional macro PEAK_THRESH_EN: adds thresh input and above_cnt output.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int unsigned FFT_LEN   = FFT_LEN_DEFAULT,
    parameter int unsigned BIN_W     = 10,
    parameter int unsigned HALF_SPEC = 1,
    parameter int unsigned SKIP_DC   = 1
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] data_modulus,
    input  logic             data_sop,
    input  logic             data_eop,
    input  logic             data_valid,
    input  logic             result_ready,
`ifdef PEAK_THRESH_EN
    input  logic [MAG_W-1:0] thresh,
    output logic [BIN_W:0]   above_cnt,
`endif
    output logic             result_valid,
    output logic [MAG_W-1:0] peak_mag,
    output logic [BIN_W-1:0] peak_bin,
    output logic             result_err,
    output logic             frame_drop
);

    fft_state_t       state_q;
    fft_state_t       state_d;
    logic             accept;
    logic             restart;
    logic             terminate;
    logic             drop_d;
    logic [BIN_W-1:0] cur_bin;
    logic             last_bin;
    logic             eligible;

    fft_bin_counter #(
        .FFT_LEN   (FFT_LEN),
        .BIN_W     (BIN_W),
        .HALF_SPEC (HALF_SPEC),
        .SKIP_DC   (SKIP_DC)
    ) u_bin_counter (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .advance      (accept),
        .restart      (restart),
`ifdef PEAK_THRESH_EN
        .data_modulus (data_modulus),
        .thresh       (thresh),
`endif
        .cur_bin      (cur_bin),
        .last_bin     (last_bin),
        .eligible     (eligible)
    );

    // Beat qualification kept apart from the FSM so last_bin never feeds back into restart
    always_comb begin
        accept    = data_valid && (((state_q == ST_IDLE) && data_sop) || (state_q == ST_ACC));
        restart   = accept && data_sop;
        terminate = accept && (data_eop || last_bin);
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drop_d       = 1'b0;
        result_valid = (state_q == ST_REPORT);
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = terminate ? ST_REPORT : ST_ACC;
                end
            end
            ST_ACC: begin
                if (terminate) begin
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                drop_d = data_valid && data_sop;
                if (result_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Peak starts at 0 and only a strictly larger eligible bin replaces it, so ties keep the lowest bin
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            peak_mag   <= '0;
            peak_bin   <= '0;
            result_err <= 1'b0;
            frame_drop <= 1'b0;
        end else begin
            frame_drop <= drop_d;
            if (restart) begin
                peak_mag <= eligible ? data_modulus : '0;
                peak_bin <= '0;
            end else if (accept && eligible && (data_modulus > peak_mag)) begin
                peak_mag <= data_modulus;
                peak_bin <= cur_bin;
            end
            if (terminate) begin
                result_err <= !(data_eop && last_bin);
            end
        end
    end

`ifdef PEAK_THRESH_EN
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            above_cnt <= '0;
        end else if (restart) begin
            above_cnt <= (BIN_W+1)'(eligible);
        end else if (accept && eligible) begin
            above_cnt <= above_cnt + (BIN_W+1)'(1);
        end
    end
`else
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed self-checking bench for fft_peak_detect with FFT_LEN=16.
module tb_fft_peak_detect;

    localparam int unsigned FFT_LEN = 16;
    localparam int unsigned BIN_W   = 4;
    localparam int unsigned NONE    = 99;

    logic             clk_50m = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      data_modulus = '0;
    logic             data_sop = 1'b0;
    logic             data_eop = 1'b0;
    logic             data_valid = 1'b0;
    logic             result_ready = 1'b1;
    logic             result_valid;
    logic [31:0]      peak_mag;
    logic [BIN_W-1:0] peak_bin;
    logic             result_err;
    logic             frame_drop;
`ifdef PEAK_THRESH_EN
    logic [31:0]      thresh = '0;
    logic [BIN_W:0]   above_cnt;
`endif

    always #5 clk_50m = ~clk_50m;

    fft_peak_detect #(
        .FFT_LEN   (FFT_LEN),
        .BIN_W     (BIN_W),
        .HALF_SPEC (1),
        .SKIP_DC   (1)
    ) dut (
        .clk_50m      (clk_50m),
        .rst_n        (rst_n),
        .data_modulus (data_modulus),
        .data_sop     (data_sop),
        .data_eop     (data_eop),
        .data_valid   (data_valid),
        .result_ready (result_ready),
`ifdef PEAK_THRESH_EN
        .thresh       (thresh),
        .above_cnt    (above_cnt),
`endif
        .result_valid (result_valid),
        .peak_mag     (peak_mag),
        .peak_bin     (peak_bin),
        .result_err   (result_err),
        .frame_drop   (frame_drop)
    );

    typedef struct {
        string       name;
        int unsigned len;
        int unsigned mult;
        bit          send_eop;
        int unsigned sb0;
        int unsigned sv0;
        int unsigned sb1;
        int unsigned sv1;
        int unsigned sb2;
        int unsigned sv2;
        logic [31:0] e_mag;
        logic [3:0]  e_bin;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;

    function automatic vec_t mk(input string n, input int unsigned len, input int unsigned mult,
                                input bit eop, input int unsigned b0, input int unsigned v0,
                                input int unsigned b1, input int unsigned v1,
                                input int unsigned b2, input int unsigned v2,
                                input int unsigned em, input int unsigned eb, input bit ee);
        vec_t v;
        v.name = n; v.len = len; v.mult = mult; v.send_eop = eop;
        v.sb0 = b0; v.sv0 = v0; v.sb1 = b1; v.sv1 = v1; v.sb2 = b2; v.sv2 = v2;
        v.e_mag = em; v.e_bin = 4'(eb); v.e_err = ee;
        return v;
    endfunction

    function automatic logic [31:0] mag_of(input vec_t v, input int unsigned b);
        if (b == v.sb0) return v.sv0;
        if (b == v.sb1) return v.sv1;
        if (b == v.sb2) return v.sv2;
        return b * v.mult;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] m);
        @(negedge clk_50m);
        data_valid   = v;
        data_sop     = s;
        data_eop     = e;
        data_modulus = m;
    endtask

    task automatic run_frame(input vec_t v);
        for (int unsigned b = 0; b < v.len; b++) begin
            drive(1'b1, b == 0, v.send_eop && (b == v.len - 1), mag_of(v, b));
            if (b == v.len - 1) chk({v.name, "_early"}, 32'(result_valid), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk({v.name, "_valid"}, 32'(result_valid), 32'd1);
        chk({v.name, "_mag"}, peak_mag, v.e_mag);
        chk({v.name, "_bin"}, 32'(peak_bin), 32'(v.e_bin));
        chk({v.name, "_err"}, 32'(result_err), 32'(v.e_err));
        @(negedge clk_50m);
        chk({v.name, "_release"}, 32'(result_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]      snap_mag;
        logic [BIN_W-1:0] snap_bin;
        logic             snap_err;
        int               drops;
        bit               stable;
        bit               rv_seen;

        vecs[0] = mk("ramp_peak5",   16, 10, 1, 5, 500,  NONE, 0,    NONE, 0,    500, 5, 0);
        vecs[1] = mk("tie_dc",       16, 1,  1, 3, 900,  7, 900,     0, 5000,    900, 3, 0);
        vecs[2] = mk("upper_half",   16, 1,  1, 12, 9999, 6, 40,     NONE, 0,    40,  6, 0);
        vecs[3] = mk("short_eop9",   10, 10, 1, 4, 300,  NONE, 0,    NONE, 0,    300, 4, 1);
        vecs[4] = mk("overrun",      16, 10, 0, NONE, 0, NONE, 0,    NONE, 0,    70,  7, 1);
        vecs[5] = mk("sop_eop_1bin", 1,  0,  1, 0, 777,  NONE, 0,    NONE, 0,    0,   0, 1);
        vecs[6] = mk("bin7_edge",    16, 0,  1, 7, 1,    8, 1000,    1, 0,       1,   7, 0);
        vecs[7] = mk("bin1_only",    16, 0,  1, 1, 5,    0, 9000,    15, 9000,   5,   1, 0);

        // reset state
        @(negedge clk_50m);
        @(negedge clk_50m);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_mag", peak_mag, 32'd0);
        chk("rst_bin", 32'(peak_bin), 32'd0);
        chk("rst_err", 32'(result_err), 32'd0);
        chk("rst_drop", 32'(frame_drop), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_frame(vecs[i]);

        // sop at bin 4 aborts and restarts the frame
        rv_seen = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd5000);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        for (int unsigned b = 0; b < 16; b++) begin
            drive(1'b1, b == 0, b == 15, (b == 6) ? 32'd600 : b * 10);
            if (result_valid) rv_seen = 1'b1;
        end
        chk("abort_no_result", 32'(rv_seen), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("abort_valid", 32'(result_valid), 32'd1);
        chk("abort_mag", peak_mag, 32'd600);
        chk("abort_bin", 32'(peak_bin), 32'd6);
        chk("abort_err", 32'(result_err), 32'd0);
        @(negedge clk_50m);

        // backpressure: result held while the next frame's sop is dropped
        result_ready = 1'b0;
        for (int unsigned b = 0; b < 16; b++) drive(1'b1, b == 0, b == 15, mag_of(vecs[0], b));
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("bp_valid", 32'(result_valid), 32'd1);
        snap_mag = peak_mag;
        snap_bin = peak_bin;
        snap_err = result_err;
        drops = 0;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50m);
            if (frame_drop) drops++;
            if (!result_valid || peak_mag !== snap_mag || peak_bin !== snap_bin || result_err !== snap_err)
                stable = 1'b0;
            data_valid   = (i >= 2) && (i <= 5);
            data_sop     = (i == 2);
            data_eop     = 1'b0;
            data_modulus = 32'd4000;
        end
        chk("bp_drop_pulses", 32'(drops), 32'd1);
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_mag", peak_mag, 32'd500);
        result_ready = 1'b1;
        @(negedge clk_50m);
        chk("bp_idle_after_ready", 32'(result_valid), 32'd0);
        drive(1'b1, 1'b0, 1'b1, 32'd9999);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("idle_ignores_nonsop", 32'(result_valid), 32'd0);
        run_frame(vecs[1]);

        // asynchronous reset at bin 8
        for (int unsigned b = 0; b < 9; b++) drive(1'b1, b == 0, 1'b0, b * 10);
        @(posedge clk_50m);
        #2;
        data_valid = 1'b0;
        data_sop   = 1'b0;
        chk("pre_rst_mag", peak_mag, 32'd70);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(result_valid), 32'd0);
        chk("arst_mag", peak_mag, 32'd0);
        chk("arst_bin", 32'(peak_bin), 32'd0);
        chk("arst_err", 32'(result_err), 32'd0);
        chk("arst_drop", 32'(frame_drop), 32'd0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 32'd50);
        drive(1'b1, 1'b0, 1'b0, 32'd60);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        @(negedge clk_50m);
        chk("post_rst_no_result", 32'(result_valid), 32'd0);
        run_frame(vecs[0]);

`ifdef PEAK_THRESH_EN
        thresh = 32'd100;
        for (int unsigned b = 0; b < 16; b++) drive(1'b1, b == 0, b == 15, 32'd50);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        chk("thr_valid", 32'(result_valid), 32'd1);
        chk("thr_mag", peak_mag, 32'd0);
        chk("thr_bin", 32'(peak_bin), 32'd0);
        chk("thr_above", 32'(above_cnt), 32'd0);
        @(negedge clk_50m);
`else
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 Parameter FFT_LEN, default 1024: number of FFT bins per frame; shall be a power of two.
REQ-002 Parameter BIN_W, default 10: bin-index width; shall equal log2(FFT_LEN).
REQ-003 Parameter HALF_SPEC, default 1: when 1, only bins 0..FFT_LEN/2-1 are eligible for the peak.
REQ-004 Parameter SKIP_DC, default 1: when 1, bin 0 is not eligible for the peak.
REQ-005 clk_50m  input  1  single clock; all logic shall be clocked on its rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 data_modulus  input  32  unsigned bin magnitude from the modulus stage.
REQ-008 data_sop  input  1  first bin of frame; qualified by data_valid.
REQ-009 data_eop  input  1  last bin of frame; qualified by data_valid.
REQ-010 data_valid  input  1  beat valid; no backpressure toward upstream.
REQ-011 result_ready  input  1  downstream accepts the result.
REQ-012 result_valid  output  1  peak result available.
REQ-013 peak_mag  output  32  largest eligible magnitude of the frame.
REQ-014 peak_bin  output  BIN_W  bin index of peak_mag.
REQ-015 result_err  output  1  frame length was not FFT_LEN; qualified by result_valid.
REQ-016 frame_drop  output  1  one-cycle pulse when an sop beat arrives while in REPORT.

Function
REQ-017 The FSM shall have states IDLE, ACC and REPORT.
REQ-018 IDLE: an sop&valid beat shall load bin count 0, seed the peak from that beat and enter ACC; non-sop beats shall be ignored.
REQ-019 ACC: each valid beat shall increment the bin count; an eligible beat shall replace the peak only if strictly greater, so ties keep the lowest bin.
REQ-020 ACC: an eop beat shall enter REPORT; result_err shall be 1 if the count at eop is not FFT_LEN-1.
REQ-021 ACC: a beat at count FFT_LEN-1 without eop shall enter REPORT with result_err=1.
REQ-022 ACC: an sop beat shall abort the current frame and restart it at bin 0 with no result emitted.
REQ-023 result_valid shall assert on the cycle after the terminating beat; peak outputs shall be registered and stable while result_valid=1.
REQ-024 REPORT: result_valid&result_ready shall return the FSM to IDLE in the next cycle.
REQ-025 REPORT: input beats shall be ignored; an sop beat shall pulse frame_drop.
REQ-026 If a frame has no eligible bin, peak_mag shall be 0 and peak_bin shall be 0.
REQ-027 Latency from the eop beat to result_valid shall be exactly 1 cycle.
REQ-028 An eop beat simultaneous with sop in IDLE shall give a 1-bin frame, reported with result_err=1.

Reset
REQ-029 Reset shall set the FSM to IDLE and clear result_valid, peak_mag, peak_bin, result_err, frame_drop and the bin counter to 0.
REQ-030 Reset asserted mid-frame or in REPORT shall discard the frame; no result shall follow reset release until a new sop.

Configuration
REQ-031 Macro PEAK_THRESH_EN: when defined, the block shall add input thresh[31:0] and output above_cnt[BIN_W:0].
REQ-032 With PEAK_THRESH_EN defined, a bin shall be eligible only if data_modulus > thresh, and above_cnt shall report the count of eligible bins above thresh, valid with result_valid.
REQ-033 Without PEAK_THRESH_EN, neither port shall exist and eligibility shall depend on HALF_SPEC and SKIP_DC only.

Structure
REQ-034 Shared package fft_pkg shall hold the FSM state typedef, the MAG_W=32 constant and the default FFT_LEN.
REQ-035 One sub-module, fft_bin_counter, shall own the bin count, the wrap/overrun detection and the eligibility flag; the compare and FSM logic shall remain in fft_peak_detect.

Verification
REQ-036 FFT_LEN=16, magnitudes = bin*10 except bin 5 = 500, result_ready=1 -> peak_bin=5, peak_mag=500, result_err=0, result_valid 1 cycle after eop.
REQ-037 Bins 3 and 7 both 900, bin 0 = 5000, SKIP_DC=1, HALF_SPEC=1 -> peak_bin=3, peak_mag=900.
REQ-038 eop at bin 9 of 16 -> result_err=1 with a valid peak; an sop at bin 4 -> no result, frame restarts, next full frame reports err=0.
REQ-039 result_ready=0 for 20 cycles while the next frame's sop arrives -> frame_drop pulses once, outputs stay stable, return to IDLE after ready.
REQ-040 rst_n low at bin 8 -> all outputs 0 immediately; a following clean frame reports correctly.
REQ-041 With PEAK_THRESH_EN, thresh=100 and all bins 50 -> peak_mag=0, peak_bin=0, above_cnt=0.
